// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for a simple dual-port RAM with a 1-cycle registered read.
// Zero-fills the RAM after reset, then serves one read or write per cycle.
module ram_arbiter #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  output logic               init_done,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [A_WIDTH-1:0] req0_addr,
  input  logic [D_WIDTH-1:0] req0_wdata,
  output logic               rsp0_valid,
  output logic [D_WIDTH-1:0] rsp0_rdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic [A_WIDTH-1:0] req1_addr,
  input  logic [D_WIDTH-1:0] req1_wdata,
  output logic               rsp1_valid,
  output logic [D_WIDTH-1:0] rsp1_rdata,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [A_WIDTH-1:0] CNT_LAST = '1;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic               prio_q, prio_d;   // requester favoured on contention
  logic               rsp0_valid_q, rsp0_valid_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic               gnt0, gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      prio_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prio_q       <= prio_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    prio_d            = prio_q;
    rsp0_valid_d      = 1'b0;
    rsp1_valid_d      = 1'b0;
    gnt0              = 1'b0;
    gnt1              = 1'b0;
    ram_write_enable  = 1'b0;
    ram_address_write = '0;
    ram_data_write    = '0;
    ram_address_read  = '0;

    case (state_q)
      ST_INIT: begin
        ram_write_enable  = 1'b1;
        ram_address_write = cnt_q;
        ram_data_write    = '0;
        cnt_d             = cnt_q + A_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A lone requester always wins; on contention the favoured one wins.
        gnt0 = req0_valid & (~req1_valid | ~prio_q);
        gnt1 = req1_valid & (~req0_valid |  prio_q);
        if (gnt0) begin
          prio_d = 1'b1;
          if (req0_we) begin
            ram_write_enable  = 1'b1;
            ram_address_write = req0_addr;
            ram_data_write    = req0_wdata;
          end else begin
            ram_address_read = req0_addr;
            rsp0_valid_d     = 1'b1;
          end
        end else if (gnt1) begin
          prio_d = 1'b0;
          if (req1_we) begin
            ram_write_enable  = 1'b1;
            ram_address_write = req1_addr;
            ram_data_write    = req1_wdata;
          end else begin
            ram_address_read = req1_addr;
            rsp1_valid_d     = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Keep the RAM and requesters quiet while reset is held.
    if (rst) begin
      gnt0              = 1'b0;
      gnt1              = 1'b0;
      ram_write_enable  = 1'b0;
      ram_address_write = '0;
      ram_data_write    = '0;
      ram_address_read  = '0;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign init_done  = (state_q == ST_RUN);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = ram_data_read;
  assign rsp1_rdata = ram_data_read;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural dual-port RAM and a vector table.
module tb_ram_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic [AW-1:0] ram_address_write;
  logic [DW-1:0] ram_data_write;
  logic          ram_write_enable;
  logic [AW-1:0] ram_address_read;
  logic [DW-1:0] ram_data_read;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_address_write(ram_address_write), .ram_data_write(ram_data_write),
    .ram_write_enable(ram_write_enable), .ram_address_read(ram_address_read),
    .ram_data_read(ram_data_read)
  );

  // Simple dual-port RAM with registered read, preloaded with junk.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
    ram_data_read = 16'hDEAD;
  end
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address_write] <= ram_data_write;
    ram_data_read <= mem[ram_address_read];
  end

  typedef struct {
    logic v0; logic we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic v1; logic we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic r0; logic r1; logic we; logic [AW-1:0] aw; logic [DW-1:0] dw; logic [AW-1:0] ar;
    logic rs0; logic rs1; logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(
    input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic r0, input logic r1, input logic we, input logic [AW-1:0] aw,
    input logic [DW-1:0] dw, input logic [AW-1:0] ar,
    input logic rs0, input logic rs1, input logic [DW-1:0] rd);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.we = we; v.aw = aw; v.dw = dw; v.ar = ar;
    v.rs0 = rs0; v.rs1 = rs1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  // Caller releases reset at a negedge; checks every zero-fill cycle then RUN entry.
  task automatic init_check();
    drive(1'b1, 1'b0, 5'd1, 16'h0, 1'b1, 1'b1, 5'd2, 16'h1234);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("init_done_low", 32'(init_done), 32'd0);
      chk("init_we", 32'(ram_write_enable), 32'd1);
      chk("init_addr", 32'(ram_address_write), 32'(i));
      chk("init_data", 32'(ram_data_write), 32'd0);
      chk("init_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    chk("init_done_high", 32'(init_done), 32'd1);
    chk("run_idle_we", 32'(ram_write_enable), 32'd0);
  endtask

  initial begin
    //           v0 we0 a0   d0        v1 we1 a1   d1        r0 r1 we aw   dw        ar   rs0 rs1 rd
    vecs[0]  = mk(1, 1, 5'd3, 16'hA5A5, 0, 0, 5'd0, 16'h0,    1, 0, 1, 5'd3, 16'hA5A5, 5'd0, 0, 0, 16'h0);
    vecs[1]  = mk(0, 0, 5'd0, 16'h0,    1, 0, 5'd3, 16'h0,    0, 1, 0, 5'd0, 16'h0,    5'd3, 0, 0, 16'h0);
    vecs[2]  = mk(0, 0, 5'd0, 16'h0,    0, 0, 5'd0, 16'h0,    0, 0, 0, 5'd0, 16'h0,    5'd0, 0, 1, 16'hA5A5);
    vecs[3]  = mk(1, 0, 5'd7, 16'h0,    0, 0, 5'd0, 16'h0,    1, 0, 0, 5'd0, 16'h0,    5'd7, 0, 0, 16'h0);
    vecs[4]  = mk(0, 0, 5'd0, 16'h0,    1, 1, 5'd31, 16'hFFFF, 0, 1, 1, 5'd31, 16'hFFFF, 5'd0, 1, 0, 16'h0000);
    vecs[5]  = mk(0, 0, 5'd0, 16'h0,    1, 0, 5'd31, 16'h0,   0, 1, 0, 5'd0, 16'h0,    5'd31, 0, 0, 16'h0);
    vecs[6]  = mk(1, 0, 5'd3, 16'h0,    1, 0, 5'd31, 16'h0,   1, 0, 0, 5'd0, 16'h0,    5'd3, 0, 1, 16'hFFFF);
    vecs[7]  = mk(1, 0, 5'd3, 16'h0,    1, 0, 5'd31, 16'h0,   0, 1, 0, 5'd0, 16'h0,    5'd31, 1, 0, 16'hA5A5);
    vecs[8]  = mk(1, 0, 5'd3, 16'h0,    1, 0, 5'd31, 16'h0,   1, 0, 0, 5'd0, 16'h0,    5'd3, 0, 1, 16'hFFFF);
    vecs[9]  = mk(1, 0, 5'd3, 16'h0,    1, 0, 5'd31, 16'h0,   0, 1, 0, 5'd0, 16'h0,    5'd31, 1, 0, 16'hA5A5);
    vecs[10] = mk(1, 0, 5'd3, 16'h0,    1, 0, 5'd31, 16'h0,   1, 0, 0, 5'd0, 16'h0,    5'd3, 0, 1, 16'hFFFF);
    vecs[11] = mk(1, 0, 5'd3, 16'h0,    1, 0, 5'd31, 16'h0,   0, 1, 0, 5'd0, 16'h0,    5'd31, 1, 0, 16'hA5A5);
    vecs[12] = mk(0, 0, 5'd0, 16'h0,    0, 0, 5'd0, 16'h0,    0, 0, 0, 5'd0, 16'h0,    5'd0, 0, 1, 16'hFFFF);
    vecs[13] = mk(1, 1, 5'd5, 16'h1111, 1, 1, 5'd6, 16'h2222, 1, 0, 1, 5'd5, 16'h1111, 5'd0, 0, 0, 16'h0);
    vecs[14] = mk(1, 1, 5'd8, 16'h3333, 1, 1, 5'd6, 16'h2222, 0, 1, 1, 5'd6, 16'h2222, 5'd0, 0, 0, 16'h0);
    vecs[15] = mk(1, 0, 5'd5, 16'h0,    1, 0, 5'd6, 16'h0,    1, 0, 0, 5'd0, 16'h0,    5'd5, 0, 0, 16'h0);
    vecs[16] = mk(0, 0, 5'd0, 16'h0,    1, 0, 5'd6, 16'h0,    0, 1, 0, 5'd0, 16'h0,    5'd6, 1, 0, 16'h1111);
    vecs[17] = mk(1, 0, 5'd8, 16'h0,    0, 0, 5'd0, 16'h0,    1, 0, 0, 5'd0, 16'h0,    5'd8, 0, 1, 16'h2222);
    vecs[18] = mk(0, 0, 5'd0, 16'h0,    0, 0, 5'd0, 16'h0,    0, 0, 0, 5'd0, 16'h0,    5'd0, 1, 0, 16'h0000);

    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd4, 16'h5555, 1'b1, 1'b0, 5'd4, 16'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_we", 32'(ram_write_enable), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    init_check();

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
      chk($sformatf("v%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
      chk($sformatf("v%0d_one_ready", i), 32'(req0_ready & req1_ready), 32'd0);
      chk($sformatf("v%0d_we", i), 32'(ram_write_enable), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_waddr", i), 32'(ram_address_write), 32'(vecs[i].aw));
        chk($sformatf("v%0d_wdata", i), 32'(ram_data_write), 32'(vecs[i].dw));
      end
      if ((vecs[i].r0 & ~vecs[i].we0) | (vecs[i].r1 & ~vecs[i].we1))
        chk($sformatf("v%0d_raddr", i), 32'(ram_address_read), 32'(vecs[i].ar));
      chk($sformatf("v%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].rs0));
      chk($sformatf("v%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].rs1));
      if (vecs[i].rs0) chk($sformatf("v%0d_rsp0_rdata", i), 32'(rsp0_rdata), 32'(vecs[i].rd));
      if (vecs[i].rs1) chk($sformatf("v%0d_rsp1_rdata", i), 32'(rsp1_rdata), 32'(vecs[i].rd));
    end

    // Reset right after a read is accepted: response dropped, zero-fill restarts.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd10, 16'hBEEF, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    chk("pre_rst_write_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd10, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    chk("pre_rst_read_ready", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    @(negedge clk);
    #1;
    chk("midrst_rsp0", 32'(rsp0_valid), 32'd0);
    chk("midrst_we", 32'(ram_write_enable), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    init_check();
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd10, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    chk("post_rst_ready", 32'(req0_ready), 32'd1);
    chk("post_rst_raddr", 32'(ram_address_read), 32'd10);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    chk("post_rst_rsp0", 32'(rsp0_valid), 32'd1);
    chk("post_rst_rdata", 32'(rsp0_rdata), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_rsp0_pulse", 32'(rsp0_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
